mask_prng_bank: RTL and testbench

Parametrised mask source for the masked AES datapath. It replaces the fixed three-bit tap arrangement, where a free-running xorshift PRNG fed mask registers on the divided clock. The block holds one xorshift32 generator with runtime reseed and a warm-up phase. It delivers N_MASKS registered mask bits that refresh every REFRESH_DIV enabled cycles, with a valid flag and a refresh strobe for the cipher core.

---
 rtl/prng_pkg.sv | 19 +
 rtl/xorshift32_core.sv | 41 ++++
 rtl/mask_prng_bank.sv | 135 +++++++++++++
 tb/tb_mask_prng_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the mask PRNG bank: xorshift32 step, FSM states and default seed.
package prng_pkg;

  localparam logic [31:0] DEFAULT_SEED = 32'hCAFEBABE;

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } prng_state_e;

  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 5'd13);
    t = t ^ (t >> 5'd17);
    t = t ^ (t << 5'd5);
    return t;
  endfunction

endpackage

// File: rtl/xorshift32_core.sv
// 32-bit xorshift state register; load has priority over step.
module xorshift32_core
  import prng_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] x_o
);

  logic [31:0] x_q;
  logic [31:0] x_d;

  // Next generator state: load, step or hold.
  always_comb begin
    x_d = x_q;
    if (load_i) begin
      x_d = load_val_i;
    end else if (step_i) begin
      x_d = xorshift32_step(x_q);
    end else begin
      x_d = x_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= SEED;
    end else begin
      x_q <= x_d;
    end
  end

  assign x_o = x_q;

endmodule

// File: rtl/mask_prng_bank.sv
// Mask source for the masked AES datapath: one xorshift32 with reseed, warm-up
// and a refresh divider feeding a registered N_MASKS-bit mask.
module mask_prng_bank
  import prng_pkg::*;
#(
  parameter int          N_MASKS     = 3,
  parameter int          REFRESH_DIV = 2,
  parameter int          WARMUP      = 16,
  parameter logic [31:0] SEED        = 32'hCAFEBABE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_valid,
  input  logic [31:0]        seed_data,
  output logic               seed_ready,
  input  logic               en,
  output logic [N_MASKS-1:0] mask,
  output logic               mask_valid,
  output logic               mask_refresh,
  output logic [31:0]        rng_word
);

  localparam int WW = ($clog2(WARMUP + 1) < 1) ? 1 : $clog2(WARMUP + 1);
  localparam int DW = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam prng_state_e   START_ST  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  prng_state_e        state_q, state_d;
  logic [WW-1:0]      warm_cnt_q, warm_cnt_d;
  logic [DW-1:0]      div_q, div_d;
  logic [N_MASKS-1:0] mask_q, mask_d;
  logic               mask_valid_q, mask_valid_d;
  logic               mask_refresh_q, mask_refresh_d;
  logic               seed_ready_q;
  logic               step_s;
  logic               load_s;
  logic               reseed_s;
  logic [31:0]        load_val_s;
  logic [31:0]        x_s;

  assign reseed_s   = seed_valid & seed_ready_q;
  assign load_val_s = (seed_data == 32'h0000_0000) ? SEED : seed_data;

  xorshift32_core #(
    .SEED(SEED)
  ) u_core (
    .clk_i     (clk),
    .rst_i     (rst),
    .step_i    (step_s),
    .load_i    (load_s),
    .load_val_i(load_val_s),
    .x_o       (x_s)
  );

  // FSM, warm-up counter, refresh divider and mask next-state.
  always_comb begin
    state_d        = state_q;
    warm_cnt_d     = warm_cnt_q;
    div_d          = div_q;
    mask_d         = mask_q;
    mask_valid_d   = mask_valid_q;
    mask_refresh_d = 1'b0;
    step_s         = 1'b0;
    load_s         = 1'b0;
    if (reseed_s) begin
      load_s       = 1'b1;
      state_d      = START_ST;
      warm_cnt_d   = '0;
      div_d        = '0;
      mask_d       = '0;
      mask_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          step_s = 1'b1;
          if (warm_cnt_q == WARM_LAST) begin
            state_d    = ST_RUN;
            warm_cnt_d = '0;
            div_d      = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + WW'(1'b1);
          end
        end
        ST_RUN: begin
          if (en) begin
            step_s = 1'b1;
            if (div_q == DIV_LAST) begin
              // Mask takes the post-step word so it matches rng_word after the edge.
              div_d          = '0;
              mask_d         = N_MASKS'(xorshift32_step(x_s));
              mask_valid_d   = 1'b1;
              mask_refresh_d = 1'b1;
            end else begin
              div_d = div_q + DW'(1'b1);
            end
          end else begin
            step_s = 1'b0;
          end
        end
        default: begin
          state_d = START_ST;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= START_ST;
      warm_cnt_q     <= '0;
      div_q          <= '0;
      mask_q         <= '0;
      mask_valid_q   <= 1'b0;
      mask_refresh_q <= 1'b0;
      seed_ready_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      warm_cnt_q     <= warm_cnt_d;
      div_q          <= div_d;
      mask_q         <= mask_d;
      mask_valid_q   <= mask_valid_d;
      mask_refresh_q <= mask_refresh_d;
      seed_ready_q   <= 1'b1;
    end
  end

  assign seed_ready   = seed_ready_q;
  assign mask         = mask_q;
  assign mask_valid   = mask_valid_q;
  assign mask_refresh = mask_refresh_q;
  assign rng_word     = x_s;

endmodule

// File: tb/tb_mask_prng_bank.sv
// Scoreboard bench: three configurations of mask_prng_bank driven with directed vectors.
module tb_mask_prng_bank;

  localparam logic [31:0] SEED = 32'hCAFEBABE;

  typedef struct {
    int          cyc;
    int          inst;
    logic [31:0] rng;
    logic [31:0] msk;
    logic        mv;
    logic        mr;
    logic        sr;
    logic [4:0]  chk;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_v, sv_v, en_v;
  logic [31:0] sd_v [3];
  logic [2:0]  sr_v, mv_v, mr_v;
  logic [31:0] rng_v [3];
  logic [2:0]  mask0, mask1;
  logic [31:0] mask2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q [$];
  logic [31:0] ref_q [$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mask_prng_bank dut_def (
    .clk(clk), .rst(rst_v[0]), .seed_valid(sv_v[0]), .seed_data(sd_v[0]),
    .seed_ready(sr_v[0]), .en(en_v[0]), .mask(mask0), .mask_valid(mv_v[0]),
    .mask_refresh(mr_v[0]), .rng_word(rng_v[0])
  );

  mask_prng_bank #(.N_MASKS(3), .REFRESH_DIV(1), .WARMUP(0)) dut_w0 (
    .clk(clk), .rst(rst_v[1]), .seed_valid(sv_v[1]), .seed_data(sd_v[1]),
    .seed_ready(sr_v[1]), .en(en_v[1]), .mask(mask1), .mask_valid(mv_v[1]),
    .mask_refresh(mr_v[1]), .rng_word(rng_v[1])
  );

  mask_prng_bank #(.N_MASKS(32), .REFRESH_DIV(1), .WARMUP(0)) dut_32 (
    .clk(clk), .rst(rst_v[2]), .seed_valid(sv_v[2]), .seed_data(sd_v[2]),
    .seed_ready(sr_v[2]), .en(en_v[2]), .mask(mask2), .mask_valid(mv_v[2]),
    .mask_refresh(mr_v[2]), .rng_word(rng_v[2])
  );

  function automatic logic [31:0] xs(input logic [31:0] v);
    v = v ^ {v[18:0], 13'b0};
    v = v ^ {17'b0, v[31:17]};
    v = v ^ {v[26:0], 5'b0};
    return v;
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    case (i)
      0:       return {29'b0, mask0};
      1:       return {29'b0, mask1};
      default: return mask2;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // Monitor: cycle-tagged expectations plus refresh-driven mask scoreboard for dut_32.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.chk[0]) check({e.nm, ".rng_word"}, rng_v[e.inst], e.rng);
      if (e.chk[1]) check({e.nm, ".mask"}, mask_of(e.inst), e.msk);
      if (e.chk[2]) check({e.nm, ".mask_valid"}, {31'b0, mv_v[e.inst]}, {31'b0, e.mv});
      if (e.chk[3]) check({e.nm, ".mask_refresh"}, {31'b0, mr_v[e.inst]}, {31'b0, e.mr});
      if (e.chk[4]) check({e.nm, ".seed_ready"}, {31'b0, sr_v[e.inst]}, {31'b0, e.sr});
    end
    if (mr_v[2] === 1'b1) begin
      if (ref_q.size() == 0) begin
        check("m32.unexpected_refresh", 32'd1, 32'd0);
      end else begin
        check("m32.mask", mask2, ref_q.pop_front());
        check("m32.mask_eq_rng", mask2, rng_v[2]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int inst, input logic [31:0] rng, input logic [31:0] msk,
                          input logic mv, input logic mr, input logic sr,
                          input logic [4:0] chk, input string nm);
    exp_t x;
    x.cyc = cyc + 1; x.inst = inst; x.rng = rng; x.msk = msk;
    x.mv = mv; x.mr = mr; x.sr = sr; x.chk = chk; x.nm = nm;
    exp_q.push_back(x);
  endtask

  logic [31:0] x0, m0, x2;

  // Default instance with en=1 from a fresh start: 16 warm-up steps, then refresh every 2nd cycle.
  task automatic default_warm(input int n, input string nm);
    for (int k = 1; k <= n; k++) begin
      logic mv_e, mr_e;
      x0   = xs(x0);
      mv_e = (k >= 18);
      mr_e = (k >= 18) && (((k - 18) % 2) == 0);
      if (mr_e) m0 = {29'b0, x0[2:0]};
      push_exp(0, x0, m0, mv_e, mr_e, 1'b1, 5'b11111, nm);
      tick();
    end
  endtask

  initial begin
    int en_pat [6] = '{1, 0, 0, 1, 0, 1};
    int mr_pat [6] = '{0, 0, 0, 1, 0, 0};
    rst_v = 3'b111; sv_v = 3'b000; en_v = 3'b000;
    for (int i = 0; i < 3; i++) sd_v[i] = 32'h0;
    tick();
    for (int i = 0; i < 3; i++) push_exp(i, SEED, 32'h0, 1'b0, 1'b0, 1'b0, 5'b11111, "reset");
    tick();

    // Release: defaults start warm-up, others sit frozen in RUN.
    rst_v = 3'b000; en_v[0] = 1'b1;
    x0 = SEED; m0 = 32'h0;
    push_exp(1, SEED, 32'h0, 1'b0, 1'b0, 1'b1, 5'b11111, "w0_release");
    push_exp(2, SEED, 32'h0, 1'b0, 1'b0, 1'b1, 5'b11111, "m32_release");
    default_warm(24, "def_warm");

    // en toggling in RUN: divider resumes across idle cycles.
    for (int k = 0; k < 6; k++) begin
      en_v[0] = en_pat[k][0];
      if (en_pat[k] != 0) x0 = xs(x0);
      if (mr_pat[k] != 0) m0 = {29'b0, x0[2:0]};
      push_exp(0, x0, m0, 1'b1, mr_pat[k][0], 1'b1, 5'b11111, "def_entoggle");
      tick();
    end

    // Zero-seed reseed: SEED substituted, mask_valid drops, warm-up restarts.
    en_v[0] = 1'b1; sv_v[0] = 1'b1; sd_v[0] = 32'h0;
    push_exp(0, SEED, 32'h0, 1'b0, 1'b0, 1'b1, 5'b11111, "def_reseed0");
    tick();
    sv_v[0] = 1'b0; x0 = SEED; m0 = 32'h0;
    default_warm(20, "def_rewarm");
    en_v[0] = 1'b0;

    // WARMUP=0, REFRESH_DIV=1 vector from seed 1.
    sv_v[1] = 1'b1; sd_v[1] = 32'h1; en_v[1] = 1'b1;
    push_exp(1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 5'b11111, "w0_seed1");
    tick();
    sv_v[1] = 1'b0;
    push_exp(1, 32'h0004_2021, 32'h1, 1'b1, 1'b1, 1'b1, 5'b11111, "w0_step1");
    tick();
    push_exp(1, 32'h0408_0601, 32'h1, 1'b1, 1'b1, 1'b1, 5'b11111, "w0_step2");
    tick();

    // Reset collides with a seed handshake and a due refresh.
    rst_v[1] = 1'b1; sv_v[1] = 1'b1; sd_v[1] = 32'h1234_5678;
    push_exp(1, SEED, 32'h0, 1'b0, 1'b0, 1'b0, 5'b11111, "w0_rst_collide");
    tick();
    rst_v[1] = 1'b0; sv_v[1] = 1'b0; en_v[1] = 1'b0;
    push_exp(1, SEED, 32'h0, 1'b0, 1'b0, 1'b1, 5'b11111, "w0_after_rst");
    tick();

    // N_MASKS=32: mask tracks the reference model on every enabled step.
    sv_v[2] = 1'b1; sd_v[2] = 32'h1234_ABCD;
    push_exp(2, 32'h1234_ABCD, 32'h0, 1'b0, 1'b0, 1'b1, 5'b11111, "m32_seed");
    tick();
    sv_v[2] = 1'b0; x2 = 32'h1234_ABCD;
    for (int k = 0; k < 1000; k++) begin
      en_v[2] = ($urandom_range(0, 3) != 0);
      if (en_v[2]) begin
        x2 = xs(x2);
        ref_q.push_back(x2);
      end
      push_exp(2, x2, 32'h0, 1'b0, en_v[2], 1'b1, 5'b11001, "m32_run");
      tick();
    end
    en_v[2] = 1'b0;
    tick();
    tick();

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("ref_q_drained", ref_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
